// File: rtl/seg7_scan_if.sv
// Bus bundle for seg7_scan: datapath-side capture inputs and board-side
// segment/anode outputs. DIGITS must match the seg7_scan instance.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                lz_en;
  logic [6:0]          seg;
  logic                seg_dp;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output value, dp_in, load, lz_en,
    input  seg, seg_dp, an, frame
  );

  modport slave (
    input  value, dp_in, load, lz_en,
    output seg, seg_dp, an, frame
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous,
// tear-free commits. Define SEG7_HEX_EN to decode nibbles 10-15 as A-F.
module seg7_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1024,
  parameter int GUARD  = 2
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [PW-1:0] PC_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PC_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h01;
      4'h1: code = 7'h4F;
      4'h2: code = 7'h12;
      4'h3: code = 7'h06;
      4'h4: code = 7'h4C;
      4'h5: code = 7'h24;
      4'h6: code = 7'h20;
      4'h7: code = 7'h0F;
      4'h8: code = 7'h00;
      4'h9: code = 7'h04;
`ifdef SEG7_HEX_EN
      4'hA: code = 7'h08;
      4'hB: code = 7'h60;
      4'hC: code = 7'h31;
      4'hD: code = 7'h42;
      4'hE: code = 7'h30;
      4'hF: code = 7'h38;
`endif
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  logic [PW-1:0]     pc_q, pc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [VW-1:0]     shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic              pending_q, pending_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  logic              wrap_s;
  logic [3:0]        nib_s;
  logic [VW-1:0]     upper_s;
  logic              blank_s;

  // Scan counters and the shadow/display commit path.
  always_comb begin
    wrap_s       = (pc_q == PC_LAST) && (idx_q == IDX_LAST);
    pc_d         = pc_q + PW'(1);
    idx_d        = idx_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;

    if (pc_q == PC_LAST) begin
      pc_d = {PW{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    // A load landing on the wrap cycle goes straight to the display.
    if (bus.load) begin
      if (wrap_s) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
        pending_d  = 1'b0;
      end else begin
        shadow_val_d = bus.value;
        shadow_dp_d  = bus.dp_in;
        pending_d    = 1'b1;
      end
    end else if (wrap_s && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Output decode for the digit currently being scanned.
  always_comb begin
    nib_s    = disp_val_q[{idx_q, 2'b00} +: 4];
    upper_s  = disp_val_q >> {idx_q, 2'b00};
    blank_s  = bus.lz_en && (idx_q != {IW{1'b0}}) && (upper_s == {VW{1'b0}});
    seg_d    = blank_s ? 7'h7F : seg_decode(nib_s);
    seg_dp_d = ~disp_dp_q[idx_q];
    frame_d  = wrap_s;
    an_d     = {DIGITS{1'b1}};
    if (pc_q >= PC_GUARD) begin
      an_d[idx_q] = 1'b0;
    end else begin
      an_d = {DIGITS{1'b1}};
    end
  end

  // State and registered outputs; reset drops any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= {PW{1'b0}};
      idx_q        <= {IW{1'b0}};
      disp_val_q   <= {VW{1'b0}};
      disp_dp_q    <= {DIGITS{1'b0}};
      shadow_val_q <= {VW{1'b0}};
      shadow_dp_q  <= {DIGITS{1'b0}};
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      seg_dp_q     <= 1'b1;
      an_q         <= {DIGITS{1'b1}};
      frame_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.seg_dp = seg_dp_q;
  assign bus.an     = an_q;
  assign bus.frame  = frame_q;
endmodule
